// File: rtl/frame_fwd_pkg.sv
// Shared types and widths for the frame_fwd store-and-forward stage.
package frame_fwd_pkg;

  localparam int unsigned IFG_W  = 8;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_IFG  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/frame_fwd_buf.sv
// Frame data buffer: circular RAM whose write pointer is committed or rewound
// per frame, with the length of the frame in progress and a full flag.
module frame_fwd_buf
  import frame_fwd_pkg::*;
#(
  parameter int unsigned    DATA_W = 8,
  parameter int unsigned    DEPTH  = 64,
  localparam int unsigned   PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mark,
  input  logic              commit,
  input  logic              rewind,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W-1:0]  frame_len,
  output logic              full
);

  localparam int unsigned AW = PTR_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  start_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      start_ptr <= '0;
    end else begin
      if (rewind) begin
        wr_ptr <= start_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (mark || commit) begin
        start_ptr <= wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data   = mem[rd_ptr[AW-1:0]];
  assign frame_len = wr_ptr - start_ptr;
  assign full      = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);

endmodule

// File: rtl/frame_fwd.sv
// Store-and-forward frame stage: buffers whole RX frames, replays them on TX with
// a minimum inter-frame gap. Define FRAME_FWD_STATS_EN to add frame counters.
module frame_fwd
  import frame_fwd_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned MAX_FRAMES = 4,
  parameter int unsigned MIN_IFG    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rxd,
  input  logic              rx_dv,
  output logic [DATA_W-1:0] txd,
  output logic              tx_en,
  output logic              rx_drop,
  output logic              busy
`ifdef FRAME_FWD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_rx_frames,
  output logic [STAT_W-1:0] stat_tx_frames,
  output logic [STAT_W-1:0] stat_drop_frames
`endif
);

  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;
  localparam int unsigned QA_W  = $clog2(MAX_FRAMES);
  localparam int unsigned QP_W  = QA_W + 1;

  logic              rx_dv_d;
  logic              rx_bad;
  logic              first_beat;
  logic              frame_end;
  logic              bad_now;
  logic              wr_en;
  logic              push;
  logic              drop;
  logic              buf_full;
  logic [LEN_W-1:0]  frame_len;
  logic [DATA_W-1:0] rd_data;

  logic [LEN_W-1:0]  q_mem [MAX_FRAMES];
  logic [QP_W-1:0]   q_wr;
  logic [QP_W-1:0]   q_rd;
  logic [QP_W-1:0]   q_cnt;
  logic [QP_W-1:0]   q_cnt_d;
  logic              q_full;
  logic              q_empty;
  logic              pop;

  tx_state_e         state;
  tx_state_e         state_d;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  beat_cnt_d;
  logic [IFG_W-1:0]  ifg_cnt;
  logic [IFG_W-1:0]  ifg_cnt_d;
  logic [DATA_W-1:0] txd_d;
  logic              tx_en_d;
  logic              rd_en;

  // A frame turns bad if it cannot get a queue slot or outruns the buffer.
  assign first_beat = rx_dv && !rx_dv_d;
  assign frame_end  = !rx_dv && rx_dv_d;
  assign bad_now    = rx_bad || (first_beat && q_full) || buf_full;
  assign wr_en      = rx_dv && !bad_now;
  assign push       = frame_end && !rx_bad;
  assign drop       = frame_end && rx_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_dv_d <= 1'b0;
      rx_bad  <= 1'b0;
      rx_drop <= 1'b0;
    end else begin
      rx_dv_d <= rx_dv;
      rx_drop <= drop;
      if (frame_end) begin
        rx_bad <= 1'b0;
      end else if (rx_dv) begin
        rx_bad <= bad_now;
      end
    end
  end

  frame_fwd_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (rxd),
    .mark      (first_beat),
    .commit    (push),
    .rewind    (drop),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .frame_len (frame_len),
    .full      (buf_full)
  );

  // Length queue of committed frames awaiting TX.
  assign q_cnt   = q_wr - q_rd;
  assign q_full  = q_cnt == QP_W'(MAX_FRAMES);
  assign q_empty = q_cnt == '0;
  assign q_cnt_d = q_cnt + QP_W'(push) - QP_W'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_wr <= '0;
      q_rd <= '0;
    end else begin
      if (push) q_wr <= q_wr + QP_W'(1);
      if (pop)  q_rd <= q_rd + QP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[q_wr[QA_W-1:0]] <= frame_len;
    end
  end

  always_comb begin
    state_d    = state;
    beat_cnt_d = beat_cnt;
    ifg_cnt_d  = ifg_cnt;
    tx_en_d    = 1'b0;
    txd_d      = '0;
    pop        = 1'b0;
    rd_en      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          pop        = 1'b1;
          beat_cnt_d = q_mem[q_rd[QA_W-1:0]];
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_en_d    = 1'b1;
        txd_d      = rd_data;
        rd_en      = 1'b1;
        beat_cnt_d = beat_cnt - LEN_W'(1);
        if (beat_cnt == LEN_W'(1)) begin
          ifg_cnt_d = IFG_W'(MIN_IFG);
          state_d   = ST_IFG;
        end
      end
      ST_IFG: begin
        ifg_cnt_d = ifg_cnt - IFG_W'(1);
        if (ifg_cnt == IFG_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      ifg_cnt  <= '0;
      tx_en    <= 1'b0;
      txd      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      beat_cnt <= beat_cnt_d;
      ifg_cnt  <= ifg_cnt_d;
      tx_en    <= tx_en_d;
      txd      <= txd_d;
      busy     <= (q_cnt_d != '0) || (state_d != ST_IDLE);
    end
  end

`ifdef FRAME_FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rx_frames   <= '0;
      stat_tx_frames   <= '0;
      stat_drop_frames <= '0;
    end else begin
      if (push) stat_rx_frames <= stat_rx_frames + STAT_W'(1);
      if (state == ST_SEND && beat_cnt == LEN_W'(1)) begin
        stat_tx_frames <= stat_tx_frames + STAT_W'(1);
      end
      if (drop) stat_drop_frames <= stat_drop_frames + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_frame_fwd.sv
// Bench for frame_fwd: frame-level schedule model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_frame_fwd;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DEPTH      = 64;
  localparam int unsigned MAX_FRAMES = 4;
  localparam int unsigned MIN_IFG    = 12;
  localparam int          IFG        = int'(MIN_IFG);

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] rxd   = '0;
  logic              rx_dv = 1'b0;
  logic [DATA_W-1:0] txd;
  logic              tx_en;
  logic              rx_drop;
  logic              busy;
`ifdef FRAME_FWD_STATS_EN
  logic [31:0]       stat_rx_frames;
  logic [31:0]       stat_tx_frames;
  logic [31:0]       stat_drop_frames;
`endif

  int total = 0;
  int bad   = 0;

  frame_fwd #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .MAX_FRAMES (MAX_FRAMES),
    .MIN_IFG    (MIN_IFG)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxd     (rxd),
    .rx_dv   (rx_dv),
    .txd     (txd),
    .tx_en   (tx_en),
    .rx_drop (rx_drop),
    .busy    (busy)
`ifdef FRAME_FWD_STATS_EN
    ,
    .stat_rx_frames   (stat_rx_frames),
    .stat_tx_frames   (stat_tx_frames),
    .stat_drop_frames (stat_drop_frames)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: each committed frame gets a TX start edge s = max(commit+2, prev_end+IFG+1).
  typedef struct {
    int c;
    int s;
    int len;
    int off;
  } frm_t;

  frm_t       frames[$];
  logic [7:0] store[$];
  logic [7:0] partial[$];
  int         cyc         = 0;
  bit         m_valid     = 0;
  bit         m_prev_dv   = 0;
  bit         m_bad       = 0;
  int         next_free   = 0;
  int         last_commit = 0;
  bit         exp_en      = 0;
  bit         exp_drop    = 0;
  bit         exp_busy    = 0;
  logic [7:0] exp_d       = '0;

  always @(posedge clk) begin : model
    int   qcnt;
    int   occ;
    int   rd;
    int   s;
    bit   drop_now;
    frm_t f;
    cyc++;
    drop_now = 0;
    if (!rst_n) begin
      frames.delete();
      partial.delete();
      m_prev_dv = 0;
      m_bad     = 0;
      next_free = 0;
      m_valid   = 1;
    end else begin
      qcnt = 0;
      occ  = partial.size();
      foreach (frames[i]) begin
        if (frames[i].c < cyc && cyc <= frames[i].s - 1) qcnt++;
        rd = cyc - frames[i].s;
        if (rd < 0) rd = 0;
        if (rd > frames[i].len) rd = frames[i].len;
        occ += frames[i].len - rd;
      end
      if (rx_dv) begin
        if (!m_prev_dv) begin
          partial.delete();
          m_bad = (qcnt >= int'(MAX_FRAMES));
        end
        if (!m_bad && occ >= int'(DEPTH)) m_bad = 1;
        if (!m_bad) partial.push_back(rxd);
      end else if (m_prev_dv) begin
        if (m_bad) begin
          drop_now = 1;
        end else begin
          s = cyc + 2;
          if (next_free > s) s = next_free;
          f.c   = cyc;
          f.s   = s;
          f.len = partial.size();
          f.off = store.size();
          foreach (partial[j]) store.push_back(partial[j]);
          frames.push_back(f);
          next_free   = s + f.len + IFG + 1;
          last_commit = cyc;
        end
        partial.delete();
        m_bad = 0;
      end
      m_prev_dv = rx_dv;
    end
    exp_en   = 0;
    exp_d    = '0;
    exp_busy = 0;
    exp_drop = drop_now;
    foreach (frames[i]) begin
      if (cyc >= frames[i].s && cyc < frames[i].s + frames[i].len) begin
        exp_en = 1;
        exp_d  = store[frames[i].off + cyc - frames[i].s];
      end
      if (cyc >= frames[i].c && cyc <= frames[i].s + frames[i].len + IFG - 2) exp_busy = 1;
    end
  end

  // Per-cycle compare and TX stream capture.
  logic [7:0] got_q[$];
  int         gaps[$];
  int         low_run  = 0;
  bit         seen_hi  = 0;
  int         drops    = 0;
  int         first_tx = -1;

  always @(negedge clk) begin
    if (m_valid) begin
      check("tx_en", 32'(tx_en), 32'(exp_en));
      check("txd", 32'(txd), 32'(exp_d));
      check("busy", 32'(busy), 32'(exp_busy));
      check("rx_drop", 32'(rx_drop), 32'(exp_drop));
      if (rx_drop) drops++;
      if (tx_en) begin
        if (first_tx < 0) first_tx = cyc;
        if (seen_hi && low_run > 0) gaps.push_back(low_run);
        got_q.push_back(txd);
        seen_hi = 1;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  logic [7:0] want[$];

  task automatic clear_mon();
    got_q.delete();
    gaps.delete();
    want.delete();
    low_run  = 0;
    seen_hi  = 0;
    drops    = 0;
    first_tx = -1;
  endtask

  task automatic check_stream(input string name);
    check({name, "_len"}, 32'(got_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
      check(name, 32'(got_q[i]), 32'(want[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [7:0] b);
    tick();
    rx_dv = 1'b1;
    rxd   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      rx_dv = 1'b0;
      rxd   = '0;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    idle(2);
    check("rst_tx_en", 32'(tx_en), 32'(0));
    check("rst_txd", 32'(txd), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rx_drop", 32'(rx_drop), 32'(0));
    rst_n = 1'b1;

    // Single 4-beat frame.
    clear_mon();
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    idle(30);
    want = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_stream("s1_data");
    check("s1_latency", 32'(first_tx - last_commit), 32'(2));
    check("s1_drops", 32'(drops), 32'(0));

    // 3-beat then 5-beat frame, one idle cycle apart.
    clear_mon();
    beat(8'hA1); beat(8'hA2); beat(8'hA3);
    idle(1);
    beat(8'hB1); beat(8'hB2); beat(8'hB3); beat(8'hB4); beat(8'hB5);
    idle(40);
    want = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    check_stream("s2_data");
    check("s2_gap_cnt", 32'(gaps.size()), 32'(1));
    if (gaps.size() > 0) check("s2_gap_len", 32'(gaps[0]), 32'(13));
    check("s2_drops", 32'(drops), 32'(0));

    // Oversized frame is dropped, following short frame survives.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 70; i++) beat(8'(i + 1));
    idle(1);
    beat(8'hA5); beat(8'h5A);
    idle(40);
    want = '{8'hA5, 8'h5A};
    check_stream("s3_data");
    check("s3_drops", 32'(drops), 32'(1));
`ifdef FRAME_FWD_STATS_EN
    check("stat_rx", stat_rx_frames, 32'(1));
    check("stat_tx", stat_tx_frames, 32'(1));
    check("stat_drop", stat_drop_frames, 32'(1));
`endif

    // Eight 2-beat frames against a 4-deep length queue: frames 5 and 6 drop.
    clear_mon();
    for (int k = 0; k < 8; k++) begin
      beat(8'(8'h20 + k));
      beat(8'(8'hB0 + k));
      idle(1);
    end
    idle(100);
    for (int k = 0; k < 8; k++) begin
      if (k != 5 && k != 6) begin
        want.push_back(8'(8'h20 + k));
        want.push_back(8'(8'hB0 + k));
      end
    end
    check_stream("s4_data");
    check("s4_drops", 32'(drops), 32'(2));
    check("s4_sum", 32'(got_q.size() / 2 + drops), 32'(8));

    // Reset during the third TX beat of an 8-beat frame.
    clear_mon();
    for (int i = 0; i < 8; i++) beat(8'(8'h61 + i));
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick();
      rx_dv = 1'b0;
      rxd   = '0;
      if (tx_en) n++;
    end
    check("s5_reach_beat3", 32'(n), 32'(3));
    rst_n = 1'b0;
    tick();
    check("s5_rst_tx_en", 32'(tx_en), 32'(0));
    check("s5_rst_txd", 32'(txd), 32'(0));
    check("s5_rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    idle(20);
    want = '{8'h61, 8'h62, 8'h63};
    check_stream("s5_partial");
    clear_mon();
    beat(8'h71); beat(8'h72);
    idle(20);
    want = '{8'h71, 8'h72};
    check_stream("s5_after");
    check("s5_drops", 32'(drops), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
